// File: rtl/whiten_seq.sv
// Run sequencer for the whitening pipeline: LOAD -> COV -> CONV -> EIG -> PROJ,
// with timeouts on the two handshaked stages, abort, and a per-run cycle counter.
module whiten_seq #(
    parameter int COV_LAT  = 4,
    parameter int CONV_LAT = 3,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             eig_done,
    input  logic             proj_done,
    output logic             load_en,
    output logic             eig_start,
    output logic             proj_start,
    output logic [2:0]       stage,
    output logic             busy,
    output logic             f,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_LOAD     = 3'd1,
        S_COV      = 3'd2,
        S_CONV     = 3'd3,
        S_EIG      = 3'd4,
        S_PROJ     = 3'd5,
        S_FINISHED = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    localparam int MAX_A   = (COV_LAT > CONV_LAT) ? COV_LAT : CONV_LAT;
    localparam int MAX_LAT = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int WAIT_W  = $clog2(MAX_LAT + 1);

    localparam logic [WAIT_W-1:0] COV_END  = WAIT_W'(COV_LAT - 1);
    localparam logic [WAIT_W-1:0] CONV_END = WAIT_W'(CONV_LAT - 1);
    localparam logic [WAIT_W-1:0] TMO_END  = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [CNT_W-1:0]  RUN_MAX  = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               in_run;
    logic [CNT_W-1:0]   run_inc;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
            run_cnt_q  <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            run_cnt_q  <= run_cnt_d;
            cycles_q   <= cycles_d;
        end
    end

    assign in_run  = (state_q >= S_LOAD) && (state_q <= S_PROJ);
    assign run_inc = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + CNT_W'(1);

    // Handshake: a stage start is a one-cycle pulse on the first cycle of EIG/PROJ;
    // the matching done is a level accepted on any later cycle of that state, so a
    // done left over from a previous run cannot complete the stage immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:     if (start) state_d = S_LOAD;
            S_LOAD:     state_d = S_COV;
            S_COV:      if (wait_cnt_q == COV_END) state_d = S_CONV;
            S_CONV:     if (wait_cnt_q == CONV_END) state_d = S_EIG;
            S_EIG: begin
                if (wait_cnt_q != '0 && eig_done) state_d = S_PROJ;
                else if (wait_cnt_q == TMO_END)   state_d = S_ERROR;
            end
            S_PROJ: begin
                if (wait_cnt_q != '0 && proj_done) state_d = S_FINISHED;
                else if (wait_cnt_q == TMO_END)    state_d = S_ERROR;
            end
            S_FINISHED: if (!start) state_d = S_WAIT;
            S_ERROR:    if (!start) state_d = S_WAIT;
            default:    state_d = S_WAIT;
        endcase
        if (abort && in_run) state_d = S_WAIT;
    end

    // Counters: wait_cnt restarts on every state change; the run counter includes
    // the final PROJ cycle, hence the incremented value is what lands in cycles.
    always_comb begin
        wait_cnt_d = '0;
        if (state_d == state_q)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

        run_cnt_d = run_cnt_q;
        if (state_q == S_WAIT && state_d == S_LOAD)
            run_cnt_d = '0;
        else if (in_run)
            run_cnt_d = run_inc;

        cycles_d = cycles_q;
        if (state_q == S_PROJ && state_d == S_FINISHED)
            cycles_d = run_inc;
    end

    always_comb begin
        load_en    = (state_q == S_LOAD);
        eig_start  = (state_q == S_EIG)  && (wait_cnt_q == '0);
        proj_start = (state_q == S_PROJ) && (wait_cnt_q == '0);
        stage      = state_q;
        busy       = in_run;
        f          = (state_q == S_FINISHED);
        err        = (state_q == S_ERROR);
        cycles     = cycles_q;
    end

endmodule

// File: tb/tb_whiten_seq.sv
// Bench for whiten_seq: directed and random runs, outcomes predicted from the
// stage latencies and compared by a monitor against f/err/abort events.
module tb_whiten_seq;

    localparam int COV_LAT  = 4;
    localparam int CONV_LAT = 3;
    localparam int TIMEOUT  = 16;
    localparam int CNT_W    = 16;
    localparam int W        = CNT_W + 2;

    localparam logic [1:0] K_FIN = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;
    localparam logic [1:0] K_ABT = 2'd2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             eig_done;
    logic             proj_done;
    logic             load_en;
    logic             eig_start;
    logic             proj_start;
    logic [2:0]       stage;
    logic             busy;
    logic             f;
    logic             err;
    logic [CNT_W-1:0] cycles;

    whiten_seq #(
        .COV_LAT (COV_LAT),
        .CONV_LAT(CONV_LAT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .eig_done  (eig_done),
        .proj_done (proj_done),
        .load_en   (load_en),
        .eig_start (eig_start),
        .proj_start(proj_start),
        .stage     (stage),
        .busy      (busy),
        .f         (f),
        .err       (err),
        .cycles    (cycles)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    int last_ok = 0;
    int exp_loads = 0;
    int exp_projs = 0;
    int seen_loads = 0;
    int seen_projs = 0;
    int cyc = 0;
    int load_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outcome of a run from the stage latencies alone.
    task automatic push_expect(input int le, input int lp, input int abort_at);
        logic [1:0] k;
        int c;
        int total;
        if (abort_at >= 0) begin
            k = K_ABT;
            c = last_ok;
        end else if (le < 1 || le >= TIMEOUT) begin
            k = K_ERR;
            c = last_ok;
        end else if (lp < 1 || lp >= TIMEOUT) begin
            k = K_ERR;
            c = last_ok;
            exp_projs++;
        end else begin
            exp_projs++;
            total = 1 + COV_LAT + CONV_LAT + (le + 1) + (lp + 1);
            c = (total > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : total;
            k = K_FIN;
            last_ok = c;
        end
        exp_q.push_back({k, c[CNT_W-1:0]});
    endtask

    // ---------------- monitor ----------------
    bit f_p = 1'b0;
    bit err_p = 1'b0;
    bit busy_p = 1'b0;

    always @(negedge clk) begin
        logic [2:0] dec_exp;
        logic [1:0] kind;
        logic [W-1:0] rec;
        if (rst) begin
            f_p = 1'b0;
            err_p = 1'b0;
            busy_p = 1'b0;
        end else begin
            cyc++;
            dec_exp = {(stage >= 3'd1 && stage <= 3'd5), (stage == 3'd6), (stage == 3'd7)};
            check("status_decode", {busy, f, err}, dec_exp);
            if (load_en) begin
                seen_loads++;
                load_cyc = cyc;
            end
            if (eig_start) check("load_to_eig_start", cyc - load_cyc, 1 + COV_LAT + CONV_LAT);
            if (proj_start) seen_projs++;
            if ((f && !f_p) || (err && !err_p) || (!busy && busy_p && !f && !err)) begin
                kind = f ? K_FIN : (err ? K_ERR : K_ABT);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_end: kind %0d with nothing expected", kind);
                end else begin
                    rec = exp_q.pop_front();
                    check("end_kind", kind, rec[W-1:CNT_W]);
                    check("cycles", cycles, rec[CNT_W-1:0]);
                end
            end
            f_p = f;
            err_p = err;
            busy_p = busy;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_pulse(input bit use_proj, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (use_proj ? proj_start : eig_start) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input int le, input int lp, input int abort_at,
                       input bit stale, input bit hold, input bit rst_mid);
        bit got;
        exp_loads++;
        if (rst_mid) exp_projs++;
        else push_expect(stale ? 1 : le, lp, abort_at);
        @(negedge clk);
        start = 1'b1;
        if (stale) eig_done = 1'b1;
        @(negedge clk);
        check("load_after_start", load_en, 1);
        if (!hold) start = 1'b0;
        wait_pulse(1'b0, got);
        check("eig_start_seen", got, 1);
        if (!got) begin
            start = 1'b0;
            eig_done = 1'b0;
            return;
        end
        if (abort_at >= 0) begin
            repeat (abort_at) @(negedge clk);
            abort = 1'b1;
            eig_done = 1'b1;
            @(negedge clk);
            check("abort_stage", stage, 0);
            check("abort_f_err", {f, err}, 0);
            abort = 1'b0;
            eig_done = 1'b0;
        end else if (le >= TIMEOUT) begin
            repeat (TIMEOUT - 1) @(negedge clk);
            check("eig_last_cycle", stage, 4);
            @(negedge clk);
            check("eig_timeout_err", err, 1);
            check("eig_timeout_f", f, 0);
        end else begin
            if (stale) begin
                @(negedge clk);
                check("stale_ignored", stage, 4);
                @(negedge clk);
                check("stale_to_proj", stage, 5);
                eig_done = 1'b0;
            end else begin
                repeat (le) @(negedge clk);
                eig_done = 1'b1;
                @(negedge clk);
                eig_done = 1'b0;
            end
            wait_pulse(1'b1, got);
            check("proj_start_seen", got, 1);
            if (rst_mid) begin
                repeat (2) @(negedge clk);
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check("rst_stage", stage, 0);
                check("rst_pulses", {load_en, eig_start, proj_start}, 0);
                check("rst_status", {busy, f, err}, 0);
                check("rst_cycles", cycles, 0);
                last_ok = 0;
                start = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #2 rst = 1'b0;
                @(negedge clk);
            end else if (lp >= TIMEOUT) begin
                repeat (TIMEOUT - 1) @(negedge clk);
                check("proj_last_cycle", stage, 5);
                @(negedge clk);
                check("proj_timeout_err", err, 1);
            end else begin
                repeat (lp) @(negedge clk);
                proj_done = 1'b1;
                @(negedge clk);
                proj_done = 1'b0;
                check("finish_f", f, 1);
                if (hold) begin
                    repeat (5) @(negedge clk);
                    check("hold_f", f, 1);
                    check("hold_stage", stage, 6);
                    start = 1'b0;
                    @(negedge clk);
                    check("release_f", f, 0);
                    check("release_stage", stage, 0);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int le;
        int lp;
        int ab;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        eig_done = 1'b0;
        proj_done = 1'b0;
        #1;
        check("reset_stage", stage, 0);
        check("reset_status", {busy, f, err, load_en, eig_start, proj_start}, 0);
        check("reset_cycles", cycles, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        run(10, 5, -1, 1'b0, 1'b0, 1'b0);
        run(TIMEOUT, 5, -1, 1'b0, 1'b0, 1'b0);
        run(1, 3, -1, 1'b1, 1'b0, 1'b0);
        run(TIMEOUT - 1, 2, -1, 1'b0, 1'b0, 1'b0);
        run(10, 5, 3, 1'b0, 1'b0, 1'b0);
        run(4, 4, -1, 1'b0, 1'b0, 1'b0);
        run(5, 8, -1, 1'b0, 1'b0, 1'b1);
        run(TIMEOUT, 5, -1, 1'b0, 1'b0, 1'b0);
        run(3, 3, -1, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            le = $urandom_range(1, TIMEOUT + 2);
            lp = $urandom_range(1, TIMEOUT + 1);
            ab = -1;
            if ($urandom_range(0, 4) == 0)
                ab = $urandom_range(0, (le < TIMEOUT - 1) ? le : TIMEOUT - 1);
            run(le, lp, ab, 1'b0, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("load_en_count", seen_loads, exp_loads);
        check("proj_start_count", seen_projs, exp_projs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/whiten_seq.md
Name: whiten_seq

Overview:
Control sequencer for the data-whitening datapath. Steps one run through the pipeline in order: input capture, covariance settle, double conversion, eigen-decomposition, then projection multiply. Issues stage start pulses and waits for stage done handshakes, with timeout and abort. Reports status, and the cycle count of each successful run, to the top-level ICA controller.

Parameters:
COV_LAT, 4, cycles allowed for the center/transpose/multiply covariance path to settle (>=1)
CONV_LAT, 3, cycles allowed for the to_double conversion registers (>=1)
TIMEOUT, 4096, maximum cycles spent in EIG or PROJ before error (>=2)
CNT_W, 16, width of the run cycle counter

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  run request (level)
abort  in  1  cancel current run (level, sampled each cycle)
eig_done  in  1  eigenvalue_decomposition complete
proj_done  in  1  projection multiply complete
load_en  out  1  one-cycle pulse; input matrix register captures mat
eig_start  out  1  one-cycle pulse to eigen-decomposition
proj_start  out  1  one-cycle pulse to projection multiply
stage  out  3  current state code
busy  out  1  high in LOAD..PROJ
f  out  1  run finished successfully
err  out  1  run timed out
cycles  out  CNT_W  length of last successful run

Behaviour:
- State codes: WAIT=0, LOAD=1, COV=2, CONV=3, EIG=4, PROJ=5, FINISHED=6, ERROR=7. stage equals the registered state.
- Internal wait_cnt clears to 0 on every state entry and increments each cycle the state is held.
- All outputs are decoded from registered state and counters. No combinational path from inputs to outputs.
- Reset (async, any time, including mid-run): state=WAIT, wait_cnt=0, run counter=0, cycles=0. All 1-bit outputs are 0.
- WAIT: start=1 -> LOAD next cycle. Otherwise stay.
- LOAD: lasts exactly 1 cycle, with load_en=1. Then -> COV.
- COV: held COV_LAT cycles (exit when wait_cnt==COV_LAT-1), then -> CONV.
- CONV: held CONV_LAT cycles, then -> EIG.
- EIG:
  - eig_start=1 only in the entry cycle (wait_cnt==0).
  - eig_done is ignored in the entry cycle, to reject stale done.
  - From wait_cnt>=1, eig_done=1 -> PROJ next cycle.
  - If wait_cnt==TIMEOUT-1 and eig_done=0 -> ERROR.
  - A done in the same cycle as the timeout condition wins (-> PROJ).
- PROJ: identical rules, using proj_start/proj_done. Success -> FINISHED.
- FINISHED: f=1. Stay while start=1. start=0 -> WAIT. A new run needs start to drop and rise again.
- ERROR: err=1. Same exit rule as FINISHED.
- abort=1 in LOAD..PROJ -> WAIT next cycle.
  - abort has priority over done and timeout.
  - No f or err is raised, and cycles is unchanged.
  - abort is ignored in WAIT, FINISHED and ERROR.
- Run counter:
  - Cleared on entry to LOAD.
  - Increments every cycle in LOAD..PROJ inclusive, saturating at 2^CNT_W-1.
  - Copied to cycles on the transition into FINISHED.
  - cycles holds its value through later aborts and errors until the next successful run.
- busy=1 exactly when stage is 1..5.
- f, err and busy are mutually exclusive.

Test Plan:
- Nominal run (COV_LAT=4, CONV_LAT=3): start pulse; eig_done asserted 10 cycles after eig_start, proj_done 5 cycles after proj_start.
  - load_en pulses once, the cycle after start is sampled.
  - eig_start appears 8 cycles after load_en.
  - f rises after 25 busy cycles; cycles=25; stage walks 0,1,2,3,4,5,6.
- Timeout (TIMEOUT=16): eig_done held low.
  - ERROR is entered after exactly 16 EIG cycles; err=1, f=0, proj_start never pulses.
  - cycles keeps its previous value.
- Stale done: eig_done held high from before EIG entry.
  - Not accepted in the entry cycle.
  - PROJ is entered on the second EIG cycle.
- Done at boundary: eig_done asserted only in EIG cycle 15 with TIMEOUT=16 -> PROJ, not ERROR.
- Abort: abort=1 in EIG cycle 3, together with eig_done=1.
  - Next state is WAIT; f=0, err=0, busy drops.
  - A fresh start then runs normally.
- Reset mid-PROJ, plus start held in FINISHED:
  - Async rst returns all outputs and cycles to 0 immediately.
  - After a completed run with start held high, f stays 1 and no new load_en occurs until start is low for at least one cycle.
